// File: rtl/ctrl_seq.sv
// ctrl_seq: parametrised instruction-sequencing control FSM.
//
// Fetches an opcode word (and, for ALU/JMP, a parameter word) over the
// memory data bus and drives registered datapath control outputs.
// Instruction classes in d[W-1:W-2]:
//   00 NOP (d[W-3]=1 is HALT), 01 ALU, 10 JMP, 11 LDX.
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   run, step           : run rising edge / step pulse leave HALT
//   bus_data_in         : memory read data (opcode or parameter word)
//   mem_op_done         : memory handshake completion
//   flag_carry/zero     : ALU flags used by conditional jumps
//   mem_ctrl_op .. mux_sel : registered datapath control outputs
//   halted, fault       : in HALT / sticky memory-timeout fault
//   instr_count         : retired-instruction counter
//
// Optional feature macro: CTRL_INSTR_COUNT_EN. When defined, instr_count
// counts retired instructions; otherwise the counter is not built and
// instr_count is tied to zero.
module ctrl_seq #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int REG_SEL_WIDTH  = 2,
  parameter int MEM_TIMEOUT    = 15,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     step,
  output logic [1:0]               mem_ctrl_op,
  output logic [2:0]               addr_reg_op,
  output logic                     addr_sel,
  output logic [3:0]               alu_op,
  output logic                     reg_op,
  output logic [REG_SEL_WIDTH-1:0] reg_sel_in,
  output logic [REG_SEL_WIDTH-1:0] reg_sel_1,
  output logic [REG_SEL_WIDTH-1:0] reg_sel_2,
  output logic [1:0]               mux_sel,
  input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
  input  logic                     mem_op_done,
  input  logic                     flag_carry,
  input  logic                     flag_zero,
  output logic                     halted,
  output logic                     fault,
  output logic [COUNT_WIDTH-1:0]   instr_count
);

  localparam int W = DATA_BUS_WIDTH;
  localparam int R = REG_SEL_WIDTH;

  localparam logic [1:0] MEM_NOP   = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;
  localparam logic [2:0] AR_NOP    = 3'b000;
  localparam logic [2:0] AR_INC    = 3'b011;
  localparam logic       SEL_PC    = 1'b0;
  localparam logic       SEL_MAR   = 1'b1;
  localparam logic [3:0] ALU_THR   = 4'd0;
  localparam logic       REG_NOP   = 1'b0;
  localparam logic       REG_WRITE = 1'b1;
  localparam logic [1:0] MUX_ALU   = 2'd0;
  localparam logic [1:0] MUX_MEM   = 2'd1;

  localparam logic [1:0] CLS_NOP = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_JMP = 2'b10;
  localparam logic [1:0] CLS_LDX = 2'b11;

  typedef enum logic [3:0] {
    S_HALT, S_FETCH, S_DECODE, S_ALU_OP, S_LDX_READ,
    S_LDX_WRITE, S_JMP_PARAM, S_INC_PC, S_FAULT
  } state_t;

  state_t         state, state_next;
  logic [W-3:0]   ir;
  logic           ir_load;
  logic           halt_pending, pend_next;
  logic           step_mode, step_next;
  logic           run_d;
  logic [7:0]     tcnt;

  logic [1:0]     mem_n;
  logic [2:0]     ar_n;
  logic           asel_n;
  logic [3:0]     alu_n;
  logic           rop_n;
  logic [R-1:0]   rin_n, rs1_n, rs2_n;
  logic [1:0]     mux_n;

  // Opcode-word fields are decoded straight off the bus in DECODE; later
  // states use the latched copy in ir (which also holds the jump addr_sel).
  logic [1:0] cls;
  logic       wait_state, timed_out, jmp_taken;

  assign cls        = bus_data_in[W-1:W-2];
  assign jmp_taken  = (!bus_data_in[W-3] | flag_carry) & (!bus_data_in[W-4] | flag_zero);
  assign wait_state = (state == S_DECODE) || (state == S_ALU_OP) || (state == S_LDX_READ) ||
                      (state == S_LDX_WRITE) || (state == S_JMP_PARAM);
  // A done arriving on the limit cycle wins over the timeout.
  assign timed_out  = wait_state && !mem_op_done && (tcnt == 8'(MEM_TIMEOUT));

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_HALT;
      ir           <= '0;
      halt_pending <= 1'b0;
      step_mode    <= 1'b0;
      run_d        <= 1'b0;
      tcnt         <= '0;
      mem_ctrl_op  <= MEM_NOP;
      addr_reg_op  <= AR_NOP;
      addr_sel     <= SEL_PC;
      alu_op       <= ALU_THR;
      reg_op       <= REG_NOP;
      reg_sel_in   <= '0;
      reg_sel_1    <= '0;
      reg_sel_2    <= '0;
      mux_sel      <= MUX_ALU;
      halted       <= 1'b1;
      fault        <= 1'b0;
    end else begin
      state        <= state_next;
      halt_pending <= pend_next;
      step_mode    <= step_next;
      run_d        <= run;
      if (ir_load) ir <= bus_data_in[W-3:0];
      if (!wait_state || mem_op_done || state_next != state) tcnt <= '0;
      else tcnt <= tcnt + 8'd1;
      mem_ctrl_op  <= mem_n;
      addr_reg_op  <= ar_n;
      addr_sel     <= asel_n;
      alu_op       <= alu_n;
      reg_op       <= rop_n;
      reg_sel_in   <= rin_n;
      reg_sel_1    <= rs1_n;
      reg_sel_2    <= rs2_n;
      mux_sel      <= mux_n;
      halted       <= (state_next == S_HALT);
      fault        <= fault | (state_next == S_FAULT);
    end
  end

  // Next-state logic, including halt_pending / step_mode updates.
  always_comb begin
    state_next = state;
    pend_next  = halt_pending;
    step_next  = step_mode;
    ir_load    = 1'b0;
    case (state)
      S_HALT: begin
        if (step) begin
          state_next = S_FETCH;
          step_next  = 1'b1;
        end else if (run && !run_d) begin
          state_next = S_FETCH;
          step_next  = 1'b0;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        if (timed_out) state_next = S_FAULT;
        else if (mem_op_done) begin
          ir_load = 1'b1;
          case (cls)
            CLS_NOP: begin
              state_next = S_INC_PC;
              if (bus_data_in[W-3]) pend_next = 1'b1;
            end
            CLS_ALU: state_next = S_ALU_OP;
            CLS_JMP: state_next = jmp_taken ? S_JMP_PARAM : S_INC_PC;
            default: state_next = bus_data_in[W-3] ? S_LDX_READ : S_LDX_WRITE;
          endcase
        end
      end
      S_ALU_OP, S_LDX_READ, S_LDX_WRITE, S_JMP_PARAM: begin
        if (timed_out) state_next = S_FAULT;
        else if (mem_op_done) state_next = S_INC_PC;
      end
      S_INC_PC: begin
        if (halt_pending || step_mode) begin
          state_next = S_HALT;
          pend_next  = 1'b0;
        end else if (!run) state_next = S_HALT;
        else state_next = S_FETCH;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_HALT;
    endcase
  end

  // Output decision for this cycle; registered above so it appears next cycle.
  // A timeout cycle drives defaults so FAULT starts with quiet outputs.
  always_comb begin
    mem_n  = MEM_NOP;
    ar_n   = AR_NOP;
    asel_n = SEL_PC;
    alu_n  = ALU_THR;
    rop_n  = REG_NOP;
    rin_n  = '0;
    rs1_n  = '0;
    rs2_n  = '0;
    mux_n  = MUX_ALU;
    if (!timed_out) begin
      case (state)
        S_FETCH: begin
          mem_n = MEM_READ;
          mux_n = MUX_MEM;
        end
        S_DECODE: begin
          if (!mem_op_done) begin
            mem_n = MEM_READ;
            mux_n = MUX_MEM;
          end else begin
            case (cls)
              CLS_ALU: ar_n = AR_INC;
              CLS_JMP: if (jmp_taken) ar_n = AR_INC;
              CLS_LDX: begin
                asel_n = SEL_MAR;
                if (bus_data_in[W-3]) begin
                  mem_n = MEM_READ;
                  mux_n = MUX_MEM;
                end else begin
                  mem_n = MEM_WRITE;
                  rs1_n = bus_data_in[W-4 -: R];
                end
              end
              default: ;
            endcase
          end
        end
        S_ALU_OP: begin
          alu_n = ir[W-3:W-6];
          rs1_n = ir[W-7 -: R];
          if (mem_op_done) begin
            rop_n = REG_WRITE;
            rs2_n = bus_data_in[W-1 -: R];
            rin_n = bus_data_in[W-1-R -: R];
          end else begin
            mem_n = MEM_READ;
            mux_n = MUX_MEM;
          end
        end
        S_LDX_READ: begin
          mux_n = MUX_MEM;
          if (mem_op_done) begin
            rop_n = REG_WRITE;
            rin_n = ir[W-4 -: R];
          end else begin
            mem_n  = MEM_READ;
            asel_n = SEL_MAR;
          end
        end
        S_LDX_WRITE: begin
          if (!mem_op_done) begin
            mem_n  = MEM_WRITE;
            asel_n = SEL_MAR;
            rs1_n  = ir[W-4 -: R];
          end
        end
        S_JMP_PARAM: begin
          rs1_n = ir[W-5 -: R];
          if (mem_op_done) begin
            ar_n   = bus_data_in[W-1:W-3];
            asel_n = ir[W-5-R];
          end else begin
            mem_n = MEM_READ;
            mux_n = MUX_MEM;
          end
        end
        S_INC_PC: ar_n = AR_INC;
        default: ;
      endcase
    end
  end

`ifdef CTRL_INSTR_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  // Retire one instruction per INC_PC pass; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else if (state == S_INC_PC) count_q <= count_q + COUNT_WIDTH'(1);
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed self-checking bench for ctrl_seq (W=8, R=2,
// MEM_TIMEOUT=4). A small memory responder answers requests with a chosen
// done latency; expected outputs are hand-computed per instruction.
module tb_ctrl_seq;

  localparam logic [2:0] AR_INC = 3'b011;

  logic        clock, reset, run, step;
  logic [1:0]  mem_ctrl_op;
  logic [2:0]  addr_reg_op;
  logic        addr_sel;
  logic [3:0]  alu_op;
  logic        reg_op;
  logic [1:0]  reg_sel_in, reg_sel_1, reg_sel_2;
  logic [1:0]  mux_sel;
  logic [7:0]  bus_data_in;
  logic        mem_op_done, flag_carry, flag_zero;
  logic        halted, fault;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;
  int retired  = 0;
  int extra;

  ctrl_seq #(.DATA_BUS_WIDTH(8), .REG_SEL_WIDTH(2), .MEM_TIMEOUT(4), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step),
    .mem_ctrl_op(mem_ctrl_op), .addr_reg_op(addr_reg_op), .addr_sel(addr_sel),
    .alu_op(alu_op), .reg_op(reg_op), .reg_sel_in(reg_sel_in),
    .reg_sel_1(reg_sel_1), .reg_sel_2(reg_sel_2), .mux_sel(mux_sel),
    .bus_data_in(bus_data_in), .mem_op_done(mem_op_done),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] expCount();
`ifdef CTRL_INSTR_COUNT_EN
    return 32'(retired[15:0]);
`else
    return 32'd0;
`endif
  endfunction

  // Memory responder: wait for a request, then raise done with data after
  // lat further cycles. Returns on the negedge where the DUT's reaction to
  // the done is visible on the outputs.
  task automatic applyStimulus(input logic [7:0] data, input int lat);
    int n = 0;
    @(negedge clock);
    while (mem_ctrl_op == 2'd0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("mem_req_seen", 32'(n < 20), 32'd1);
    repeat (lat) @(negedge clock);
    mem_op_done = 1'b1;
    bus_data_in = data;
    @(negedge clock);
    mem_op_done = 1'b0;
  endtask

  task automatic pulseStep();
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
  endtask

  task automatic countReads(input int cycles, output int reads);
    reads = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (mem_ctrl_op != 2'd0 || !halted) reads++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; bus_data_in = '0;
    mem_op_done = 1'b0; flag_carry = 1'b0; flag_zero = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state and idle HALT.
    checkOutput("rst_halted", 32'(halted), 1);
    checkOutput("rst_mem", 32'(mem_ctrl_op), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_count", 32'(instr_count), 0);
    checkOutput("rst_mux", 32'(mux_sel), 0);
    countReads(20, extra);
    checkOutput("idle_halt", 32'(extra), 0);

    // ALU 0x46 (op 1, r1=2), param 0x70 (r2=1, rin=3).
    run = 1'b1;
    applyStimulus(8'h46, 1);
    checkOutput("alu_pc_inc", 32'(addr_reg_op), 32'(AR_INC));
    run = 1'b0;
    applyStimulus(8'h70, 1);
    checkOutput("alu_regop", 32'(reg_op), 1);
    checkOutput("alu_op", 32'(alu_op), 1);
    checkOutput("alu_rs1", 32'(reg_sel_1), 2);
    checkOutput("alu_rs2", 32'(reg_sel_2), 1);
    checkOutput("alu_rin", 32'(reg_sel_in), 3);
    checkOutput("alu_mux", 32'(mux_sel), 0);
    @(negedge clock);
    retired++;
    checkOutput("alu_incpc", 32'(addr_reg_op), 32'(AR_INC));
    checkOutput("alu_incpc_sel", 32'(addr_sel), 0);
    checkOutput("alu_halted", 32'(halted), 1);
    checkOutput("alu_count", 32'(instr_count), expCount());

    // Two single steps of NOP.
    for (int i = 0; i < 2; i++) begin
      pulseStep();
      applyStimulus(8'h00, 1);
      @(negedge clock);
      retired++;
      checkOutput("step_halted", 32'(halted), 1);
      checkOutput("step_count", 32'(instr_count), expCount());
      countReads(8, extra);
      checkOutput("step_once", 32'(extra), 0);
    end

    // JMP use_c with carry=0: not taken, param never fetched.
    flag_carry = 1'b0;
    pulseStep();
    applyStimulus(8'hA2, 1);
    checkOutput("jmp_nt_ar", 32'(addr_reg_op), 0);
    @(negedge clock);
    retired++;
    checkOutput("jmp_nt_incpc", 32'(addr_reg_op), 32'(AR_INC));
    countReads(6, extra);
    checkOutput("jmp_nt_noparam", 32'(extra), 0);

    // JMP use_z with zero=0 (carry=1 irrelevant): not taken.
    flag_carry = 1'b1;
    pulseStep();
    applyStimulus(8'h90, 1);
    checkOutput("jmpz_nt_ar", 32'(addr_reg_op), 0);
    @(negedge clock);
    retired++;

    // JMP use_c with carry=1, addr_sel=MAR, param 0x20 -> addr_reg_op=001.
    pulseStep();
    applyStimulus(8'hA2, 1);
    checkOutput("jmp_t_pcinc", 32'(addr_reg_op), 32'(AR_INC));
    applyStimulus(8'h20, 1);
    checkOutput("jmp_t_arop", 32'(addr_reg_op), 32'b001);
    checkOutput("jmp_t_sel", 32'(addr_sel), 1);
    @(negedge clock);
    retired++;
    checkOutput("jmp_t_count", 32'(instr_count), expCount());
    flag_carry = 1'b0;

    // LDX read 0xF0 (reg 2), then LDX write 0xD8 (reg 3).
    pulseStep();
    applyStimulus(8'hF0, 1);
    checkOutput("ldr_mem", 32'(mem_ctrl_op), 1);
    checkOutput("ldr_sel", 32'(addr_sel), 1);
    applyStimulus(8'h55, 1);
    checkOutput("ldr_regop", 32'(reg_op), 1);
    checkOutput("ldr_rin", 32'(reg_sel_in), 2);
    checkOutput("ldr_mux", 32'(mux_sel), 1);
    @(negedge clock);
    retired++;
    pulseStep();
    applyStimulus(8'hD8, 1);
    checkOutput("ldw_mem", 32'(mem_ctrl_op), 2);
    checkOutput("ldw_sel", 32'(addr_sel), 1);
    checkOutput("ldw_rs1", 32'(reg_sel_1), 3);
    applyStimulus(8'h00, 1);
    checkOutput("ldw_done_mem", 32'(mem_ctrl_op), 0);
    @(negedge clock);
    retired++;
    checkOutput("ldx_count", 32'(instr_count), expCount());

    // HALT opcode with run held high: stays halted until run re-rises.
    run = 1'b1;
    applyStimulus(8'h20, 1);
    @(negedge clock);
    retired++;
    checkOutput("hlt_halted", 32'(halted), 1);
    countReads(10, extra);
    checkOutput("hlt_stays", 32'(extra), 0);
    run = 1'b0;
    @(negedge clock);
    run = 1'b1;
    applyStimulus(8'h20, 1);
    @(negedge clock);
    retired++;
    run = 1'b0;
    checkOutput("hlt_resume_halted", 32'(halted), 1);
    checkOutput("hlt_count", 32'(instr_count), expCount());

    // Done exactly on the timeout cycle must not fault.
    pulseStep();
    applyStimulus(8'h00, 4);
    checkOutput("tmo_edge_fault", 32'(fault), 0);
    @(negedge clock);
    retired++;
    checkOutput("tmo_edge_halted", 32'(halted), 1);

    // No done at all: FAULT after 4 wait cycles.
    begin
      int n = 0;
      pulseStep();
      @(negedge clock);
      while (mem_ctrl_op == 2'd0 && n < 20) begin
        @(negedge clock);
        n++;
      end
      checkOutput("flt_req_seen", 32'(n < 20), 1);
    end
    repeat (4) @(negedge clock);
    checkOutput("flt_early", 32'(fault), 0);
    @(negedge clock);
    checkOutput("flt_set", 32'(fault), 1);
    checkOutput("flt_mem", 32'(mem_ctrl_op), 0);
    checkOutput("flt_halted", 32'(halted), 0);
    pulseStep();
    repeat (3) @(negedge clock);
    checkOutput("flt_sticky", 32'(fault), 1);
    checkOutput("flt_mux", 32'(mux_sel), 0);

    // Reset clears the fault.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    retired = 0;
    checkOutput("rst2_fault", 32'(fault), 0);
    checkOutput("rst2_halted", 32'(halted), 1);
    checkOutput("rst2_count", 32'(instr_count), expCount());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Parametrised successor to the single-width 8-bit control FSM.
- Decodes NOP/ALU/LDX/JMP instruction classes from the memory data bus and drives the same registered control outputs, using controlpack encodings.
- Adds a parametrised register-select width and a parametrised bus width.
- Adds a HALT instruction, an external run/step handshake, a memory-wait timeout with a fault state, and corrected masked jump conditions.

Parameters:
- DATA_BUS_WIDTH, 8, instruction/param word width W; legal range W >= 6+REG_SEL_WIDTH.
- REG_SEL_WIDTH, 2, register select width; 2**REG_SEL_WIDTH registers.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_op_done in one wait state; range 1..255.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  continuous-run request; a rising edge leaves HALT.
- step  in  1  single-cycle pulse; executes exactly one instruction from HALT.
- mem_ctrl_op  out  2  MEM_NOP/MEM_READ/MEM_WRITE.
- addr_reg_op  out  3  address register op (AR_NOP, INC, ...).
- addr_sel  out  1  PC or MAR.
- alu_op  out  4  ALU operation.
- reg_op  out  1  REG_NOP/REG_WRITE.
- reg_sel_in  out  REG_SEL_WIDTH  write register select.
- reg_sel_1  out  REG_SEL_WIDTH  operand 1 select.
- reg_sel_2  out  REG_SEL_WIDTH  operand 2 select.
- mux_sel  out  2  MUX_ALU/MUX_MEM.
- bus_data_in  in  W  memory read data.
- mem_op_done  in  1  memory handshake completion.
- flag_carry  in  1  ALU carry flag.
- flag_zero  in  1  ALU zero flag.
- halted  out  1  high while in HALT.
- fault  out  1  sticky memory-timeout fault.
- instr_count  out  COUNT_WIDTH  retired instructions.

Behaviour:
- **Reset** (synchronous, while reset=1):
  - state=HALT.
  - Control outputs: MEM_NOP, AR_NOP, PC, THR, REG_NOP, all selects 0, MUX_ALU.
  - halted=1, fault=0, instr_count=0, run_d=0, timeout counter=0, step_mode=0, jmp addr_sel latch=0.
  - Reset mid-operation abandons the instruction; there is no memory write-back.
- **Output timing:** all control outputs are registered. Each cycle's combinational decision appears on the outputs one cycle later. Defaults in every state: the reset values listed above.
- **Field decode** (d = opcode word, p = param word, R = REG_SEL_WIDTH):
  - class = d[W-1:W-2].
  - NOP: d[W-3]=1 is HALT.
  - ALU: alu_op=d[W-3:W-6]; reg_sel_1=d[W-7 -: R]; p gives reg_sel_2=p[W-1 -: R], reg_sel_in=p[W-1-R -: R].
  - LDX: dir=d[W-3] (1 = mem->reg); register=d[W-4 -: R].
  - JMP: use_c=d[W-3]; use_z=d[W-4]; reg_sel_1=d[W-5 -: R]; addr_sel=d[W-5-R]; p gives addr_reg_op=p[W-1:W-3].
  - Jump taken iff (!use_c | flag_carry) & (!use_z | flag_zero); use_c=use_z=0 means unconditional.
- **States:**
  - HALT: leave to FETCH on step=1 (sets step_mode=1) or on a run rising edge, run & !run_d (sets step_mode=0). step has priority when both occur.
  - FETCH: issue MEM_READ, PC, MUX_MEM; go to DECODE.
  - DECODE: hold the read; wait for mem_op_done.
    - NOP: go to INC_PC.
    - HALT: go to INC_PC and set halt_pending.
    - ALU: INC PC; go to ALU_OP.
    - LDX read: MEM_READ at MAR; go to LDX_READ.
    - LDX write: MEM_WRITE at MAR, THR, MUX_ALU; go to LDX_WRITE.
    - JMP not taken: go to INC_PC.
    - JMP taken: INC PC; latch addr_sel; go to JMP_PARAM.
  - ALU_OP: read param; on mem_op_done issue REG_WRITE, MUX_ALU, preserving alu_op/reg_sel_1; go to INC_PC.
  - LDX_READ: on done, REG_WRITE; go to INC_PC.
  - LDX_WRITE: hold the write; on done go to INC_PC.
  - JMP_PARAM: on done drive addr_reg_op from p with the latched addr_sel; go to INC_PC.
  - INC_PC: addr INC at PC; instr_count+1, wrapping modulo 2**COUNT_WIDTH. Next state:
    - if halt_pending or step_mode: go to HALT and clear halt_pending.
    - else if run=0: go to HALT.
    - else: go to FETCH.
  - FAULT: all outputs at their defaults; fault=1; exit only via reset.
  - Illegal state encoding: go to HALT.
- **Timeout:**
  - The counter is active in DECODE, ALU_OP, LDX_READ, LDX_WRITE and JMP_PARAM.
  - It clears on state entry and when mem_op_done is seen.
  - When the count reaches MEM_TIMEOUT with no done, go to FAULT.
  - A done in the same cycle as count==MEM_TIMEOUT wins; the block does not fault.
- **Other signals:**
  - run_d is registered every cycle.
  - A step pulse outside HALT is ignored.

Optional Feature:
- Macro: CTRL_INSTR_COUNT_EN.
- Defined: instr_count counts retired instructions as specified above.
- Undefined: the counter register is not built and instr_count is tied to 0.

Test Plan:
- Reset=1 for 2 cycles, then run=0 -> halted=1, mem_ctrl_op=MEM_NOP, state stays HALT for 20 cycles.
- W=8, run rising edge, mem returns 0x46 (ALU, op 0001, r1=2) then param 0x70 (r2=1, rin=3) with 1-cycle done latency -> one cycle with reg_op=REG_WRITE, alu_op=1, reg_sel_1=2, reg_sel_2=1, reg_sel_in=3, MUX_ALU, followed by INC PC; instr_count=1.
- With run=0, pulse step with instruction 0x00 -> exactly one FETCH..INC_PC pass, then halted=1; a second step pulse repeats once more.
- JMP 0xA0 (use_c=1) with flag_carry=0 -> INC_PC only, addr_reg_op never set from the param. With flag_carry=1 and param 0x20 -> addr_reg_op=001 in JMP_PARAM.
- MEM_TIMEOUT=4, mem_op_done held low in DECODE -> enter FAULT after 4 wait cycles, fault=1, outputs at defaults; done arriving exactly on count 4 does not fault.
- HALT opcode 0x20 with run held at 1 -> halted=1 after INC_PC; resumes only after run is dropped then raised again.
